// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: queues stereo frames in a small FIFO and streams each
// one as 32 left bits then 32 right bits, MSB first, with no gap between frames.
module i2s_tx_sched #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req_valid,
    input  logic [31:0] req_left,
    input  logic [31:0] req_right,
    output logic        req_ready,
    output logic        tx_sd,
    output logic        tx_ws,
    output logic        tx_valid,
    output logic        busy,
    output logic [7:0]  frame_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t          state_q, state_d;
    logic [4:0]      bit_idx_q, bit_idx_d;
    logic [63:0]     shift_q, shift_d;
    logic [63:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tx_sd_q, tx_sd_d, tx_ws_q, tx_ws_d;
    logic            tx_valid_q, tx_valid_d, busy_q, busy_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            push, pop, frame_end, can_start;

    assign req_ready = (count_q < DEPTH_C);
    assign push      = req_valid && req_ready;
    assign frame_end = (state_q == RIGHT) && (bit_idx_q == 5'd0);
    // A new frame may only begin from idle or exactly on the last right bit,
    // which is what keeps back-to-back frames seamless.
    assign can_start = (state_q == IDLE) || frame_end;
    assign pop       = can_start && en && (count_q != '0);

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_sd_d     = tx_sd_q;
        frame_cnt_d = frame_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (pop) begin
            state_d   = LEFT;
            bit_idx_d = 5'd31;
            tx_sd_d   = mem_q[rd_ptr_q][63];
            shift_d   = mem_q[rd_ptr_q] << 1;
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end else if (can_start) begin
            state_d = IDLE;
            tx_sd_d = 1'b0;
        end else begin
            // bit_idx wraps 0 -> 31, which is exactly the LEFT -> RIGHT reload
            bit_idx_d = bit_idx_q - 5'd1;
            tx_sd_d   = shift_q[63];
            shift_d   = shift_q << 1;
            if (state_q == LEFT && bit_idx_q == 5'd0) begin
                state_d = RIGHT;
            end
        end

        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        tx_valid_d = (state_d != IDLE);
        busy_d     = (state_d != IDLE);
        tx_ws_d    = (state_d == RIGHT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_idx_q   <= 5'd0;
            tx_sd_q     <= 1'b0;
            tx_ws_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            tx_sd_q     <= tx_sd_d;
            tx_ws_q     <= tx_ws_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Payload storage is never reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wr_ptr_q] <= {req_left, req_right};
        end
    end

    assign tx_sd     = tx_sd_q;
    assign tx_ws     = tx_ws_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_i2s_tx_sched.sv
// Bench for i2s_tx_sched: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_i2s_tx_sched;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_left = '0;
    logic [31:0] req_right = '0;
    logic        req_ready, tx_sd, tx_ws, tx_valid, busy;
    logic [7:0]  frame_cnt;

    i2s_tx_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid),
        .req_left(req_left), .req_right(req_right), .req_ready(req_ready),
        .tx_sd(tx_sd), .tx_ws(tx_ws), .tx_valid(tx_valid), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int run_len = 0;
    int max_run = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a queue of frames and the bit position (0..63) of the
    // frame currently on the wire.
    logic [63:0] mq[$];
    logic [63:0] m_frame = '0;
    int          m_pos = 0;
    bit          m_act = 0;
    logic [7:0]  m_cnt = '0;
    bit          m_acc = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int sz;
        bit rdy;
        if (!rst_n) begin
            mq.delete();
            m_act = 0;
            m_pos = 0;
            m_cnt = '0;
            m_acc = 0;
        end else begin
            sz  = mq.size();
            rdy = (sz < DEPTH);
            if (m_act && m_pos < 63) begin
                m_pos++;
            end else begin
                if (m_act) m_cnt++;
                if (en && sz > 0) begin
                    m_frame = mq.pop_front();
                    m_pos   = 0;
                    m_act   = 1;
                end else begin
                    m_act = 0;
                end
            end
            m_acc = req_valid && rdy;
            if (m_acc) mq.push_back({req_left, req_right});
        end
    end

    always @(negedge clk) begin : compare
        logic [12:0] act, exp;
        act = {req_ready, tx_valid, tx_ws, tx_sd, busy, frame_cnt};
        exp = {(mq.size() < DEPTH), m_act, (m_act && m_pos >= 32),
               (m_act && m_frame[63 - m_pos]), m_act, m_cnt};
        check("cycle{rdy,vld,ws,sd,busy,cnt}", 64'(act), 64'(exp));
        if (tx_valid) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
    end

    // Called at a negedge; holds each frame until the model sees it accepted.
    task automatic push_frames(int n, bit fixed, logic [31:0] l, logic [31:0] r);
        int got = 0;
        int guard = 0;
        req_valid = 1'b1;
        req_left  = fixed ? l : $urandom;
        req_right = fixed ? r : $urandom;
        while (got < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (m_acc) begin
                got++;
                req_left  = $urandom;
                req_right = $urandom;
            end
        end
        req_valid = 1'b0;
        if (got < n) check("push_timeout", 64'(got), 64'(n));
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] lw, rw;
        int nl, nr, first, guard;
        lw = '0; rw = '0; nl = 0; nr = 0; first = -1;

        #12;
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_valid", 64'(tx_valid), 64'd0);
        check("reset_cnt", 64'(frame_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);

        // single frame with fixed data, captured from the serial stream
        req_valid = 1'b1;
        req_left  = 32'hA5A5_0001;
        req_right = 32'h8000_00FF;
        @(negedge clk);
        req_valid = 1'b0;
        check("latency_e0_valid", 64'(tx_valid), 64'd0);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                if (first < 0) first = i;
                if (!tx_ws) begin lw = {lw[30:0], tx_sd}; nl++; end
                else begin rw = {rw[30:0], tx_sd}; nr++; end
            end
        end
        check("latency_first_bit", 64'(first), 64'd0);
        check("left_bits", 64'(nl), 64'd32);
        check("right_bits", 64'(nr), 64'd32);
        check("left_word", 64'(lw), 64'hA5A5_0001);
        check("right_word", 64'(rw), 64'h8000_00FF);
        check("single_cnt", 64'(frame_cnt), 64'd1);
        check("single_idle", 64'(tx_valid), 64'd0);

        // back-to-back frames, FIFO fills, one held frame waits for a pop
        max_run = 0;
        push_frames(3, 0, '0, '0);
        check("full_ready_low", 64'(req_ready), 64'd0);
        push_frames(1, 0, '0, '0);
        wait_cycles(300);
        check("stream_run_len", 64'(max_run), 64'd256);
        check("stream_cnt", 64'(frame_cnt), 64'd5);

        // en dropped at LEFT bit 10 with one frame queued
        push_frames(2, 0, '0, '0);
        guard = 0;
        while (!(m_act && m_pos == 21) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("en_wait", 64'(guard < 200), 64'd1);
        en = 1'b0;
        wait_cycles(80);
        check("en_low_idle", 64'(tx_valid), 64'd0);
        check("en_low_cnt", 64'(frame_cnt), 64'd6);
        en = 1'b1;
        @(negedge clk);
        check("en_restart", 64'(tx_valid), 64'd1);

        // async reset at RIGHT bit 5 with one frame queued
        push_frames(1, 0, '0, '0);
        guard = 0;
        while (!(m_act && m_pos == 58) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_wait", 64'(guard < 200), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(tx_valid), 64'd0);
        check("rst_mid_ws", 64'(tx_ws), 64'd0);
        check("rst_mid_sd", 64'(tx_sd), 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_cnt", 64'(frame_cnt), 64'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(20);
        check("rst_after_idle", 64'(tx_valid), 64'd0);

        // 257 frames: frame_cnt wraps through 0 and ends at 1
        push_frames(257, 0, '0, '0);
        wait_cycles(200);
        check("wrap_cnt", 64'(frame_cnt), 64'd1);

        // random traffic with random enable
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!(req_valid && !m_acc)) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_left  = $urandom;
                req_right = $urandom;
            end
            en = ($urandom_range(0, 9) != 0);
        end
        req_valid = 1'b0;
        en = 1'b1;
        wait_cycles(250);
        check("final_idle", 64'(tx_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
